// File: rtl/block_scheduler.sv
// Thread-block scheduler: launches a kernel, hands sequential block IDs to ready
// cores in round-robin order, recycles finished cores and reports completion.
module block_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [DATA_WIDTH-1:0]                num_blocks,
  input  logic [NUM_CORES-1:0]                 core_done,
  output logic [NUM_CORES-1:0]                 core_start,
  output logic [NUM_CORES-1:0]                 core_reset,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_block_id,
  output logic [DATA_WIDTH-1:0]                blocks_done_count,
  output logic                                 busy,
  output logic                                 done
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int POP_W = $clog2(NUM_CORES + 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t                               state_reg, state_next;
  logic [NUM_CORES-1:0]                 start_reg, start_next;
  logic [NUM_CORES-1:0]                 rst_reg, rst_next;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] id_reg, id_next;
  logic [DATA_WIDTH-1:0]                total_reg, total_next;
  logic [DATA_WIDTH-1:0]                disp_reg, disp_next;
  logic [DATA_WIDTH-1:0]                cnt_reg, cnt_next;
  logic [IDX_W-1:0]                     rr_reg, rr_next;
  logic                                 done_reg, done_next;

  logic [NUM_CORES-1:0] ready;
  logic [NUM_CORES-1:0] complete;
  logic [POP_W-1:0]     pop;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W:0]       scan;
  logic [DATA_WIDTH-1:0] cnt_sum;

  // A core finishing this cycle still has start_reg set, so it is never ready here.
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign ready[gi]    = rst_reg[gi] & ~start_reg[gi];
      assign complete[gi] = start_reg[gi] & core_done[gi];
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pop = pop + POP_W'(complete[i]);
    end
  end

  assign cnt_sum = cnt_reg + DATA_WIDTH'(pop);

  // First ready core at or after the round-robin pointer, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan = {1'b0, rr_reg} + (IDX_W + 1)'(k);
      if (scan >= (IDX_W + 1)'(NUM_CORES)) begin
        scan = scan - (IDX_W + 1)'(NUM_CORES);
      end
      if (!pick_valid && ready[scan[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    start_next = start_reg;
    rst_next   = rst_reg;
    id_next    = id_reg;
    total_next = total_reg;
    disp_next  = disp_reg;
    cnt_next   = cnt_reg;
    rr_next    = rr_reg;
    done_next  = done_reg;

    if (abort && state_reg != IDLE) begin
      start_next = '0;
      rst_next   = '1;
      done_next  = 1'b0;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            total_next = num_blocks;
            disp_next  = '0;
            cnt_next   = '0;
            rr_next    = '0;
            state_next = INIT;
          end
        end
        INIT: begin
          start_next = '0;
          rst_next   = '1;
          if (total_reg == '0) begin
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
        RUN: begin
          start_next = start_reg & ~complete;
          rst_next   = rst_reg | complete;
          cnt_next   = cnt_sum;
          if (disp_reg < total_reg && pick_valid) begin
            start_next[pick_idx] = 1'b1;
            rst_next[pick_idx]   = 1'b0;
            id_next[pick_idx]    = disp_reg;
            disp_next            = disp_reg + 1'b1;
            rr_next = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + IDX_W'(1);
          end
          if (cnt_sum == total_reg) begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          start_next = '0;
          rst_next   = '1;
          if (!start) begin
            done_next  = 1'b0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      start_reg <= '0;
      rst_reg   <= '1;
      id_reg    <= '0;
      total_reg <= '0;
      disp_reg  <= '0;
      cnt_reg   <= '0;
      rr_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_next;
      rst_reg   <= rst_next;
      id_reg    <= id_next;
      total_reg <= total_next;
      disp_reg  <= disp_next;
      cnt_reg   <= cnt_next;
      rr_reg    <= rr_next;
      done_reg  <= done_next;
    end
  end

  assign core_start        = start_reg;
  assign core_reset        = rst_reg;
  assign core_block_id     = id_reg;
  assign blocks_done_count = cnt_reg;
  assign done              = done_reg;
  assign busy              = (state_reg == INIT) || (state_reg == RUN);

endmodule

// File: tb/tb_block_scheduler.sv
// Self-checking bench for block_scheduler: directed scenarios plus randomised
// kernels, all compared against a cycle-level behavioural model of the scheduler.
module tb_block_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 abort;
  logic [W-1:0]         num_blocks;
  logic [N-1:0]         core_done;
  logic [N-1:0]         core_start;
  logic [N-1:0]         core_reset;
  logic [N-1:0][W-1:0]  core_block_id;
  logic [W-1:0]         blocks_done_count;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  block_scheduler #(.NUM_CORES(N), .DATA_WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .num_blocks       (num_blocks),
    .core_done        (core_done),
    .core_start       (core_start),
    .core_reset       (core_reset),
    .core_block_id    (core_block_id),
    .blocks_done_count(blocks_done_count),
    .busy             (busy),
    .done             (done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: which cores hold a block, which IDs they hold, progress counts.
  typedef enum int {M_IDLE, M_INIT, M_RUN, M_DONE} mphase_t;
  mphase_t      m_phase;
  bit           m_run [N];
  int           m_age [N];
  int           m_lat [N];
  logic [W-1:0] m_id  [N];
  int           m_rr;
  longint       m_total, m_disp, m_cnt;
  bit           m_done;
  int           lat_mode;
  int           lat_fixed;

  task automatic model_reset();
    m_phase = M_IDLE;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_age[i] = 0; m_lat[i] = 0; m_id[i] = '0;
    end
    m_rr = 0; m_total = 0; m_disp = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input logic [N-1:0] cd);
    bit was_run [N];
    int pop;
    int c;
    bit picked;
    for (int i = 0; i < N; i++) begin
      was_run[i] = m_run[i];
      if (m_run[i]) m_age[i]++;
    end
    if (ab && m_phase != M_IDLE) begin
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_done  = 0;
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (st) begin
          m_total = longint'(num_blocks); m_disp = 0; m_cnt = 0; m_rr = 0;
          m_phase = M_INIT;
        end
        M_INIT: begin
          for (int i = 0; i < N; i++) m_run[i] = 0;
          if (m_total == 0) begin m_phase = M_DONE; m_done = 1; end
          else m_phase = M_RUN;
        end
        M_RUN: begin
          pop = 0;
          for (int i = 0; i < N; i++) begin
            if (was_run[i] && cd[i]) begin m_run[i] = 0; pop++; end
          end
          if (m_disp < m_total) begin
            picked = 0;
            for (int k = 0; k < N; k++) begin
              c = (m_rr + k) % N;
              if (!picked && !was_run[c]) begin
                picked = 1;
                m_run[c] = 1;
                m_id[c]  = W'(m_disp);
                m_age[c] = 0;
                m_lat[c] = (lat_mode != 0) ? int'($urandom_range(20, 1)) : lat_fixed;
                m_disp++;
                m_rr = (c + 1) % N;
              end
            end
          end
          m_cnt += pop;
          if (m_cnt == m_total) begin m_phase = M_DONE; m_done = 1; end
        end
        M_DONE: begin
          for (int i = 0; i < N; i++) m_run[i] = 0;
          if (!st) begin m_phase = M_IDLE; m_done = 0; end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [N-1:0] exp_start();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_run[i];
    return v;
  endfunction

  function automatic logic [N-1:0][W-1:0] exp_ids();
    logic [N-1:0][W-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_id[i];
    return v;
  endfunction

  function automatic logic [N-1:0] auto_done();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (m_run[i] && m_age[i] >= m_lat[i]) v[i] = 1'b1;
    return v;
  endfunction

  // Called at a falling edge: drive inputs, advance the model, wait past the next rising edge.
  task automatic tick(input bit st, input bit ab, input logic [N-1:0] cd);
    start = st; abort = ab; core_done = cd;
    model_edge(st, ab, cd);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [N-1:0] all1;
    all1 = '1;
    #3;
    n_cmp++; if (core_start !== '0) begin n_err++; $display("FAIL reset_core_start got %b want 0", core_start); end
    n_cmp++; if (core_reset !== all1) begin n_err++; $display("FAIL reset_core_reset got %b want %b", core_reset, all1); end
    n_cmp++; if (core_block_id !== '0) begin n_err++; $display("FAIL reset_block_id got %h want 0", core_block_id); end
    n_cmp++; if (blocks_done_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", blocks_done_count); end
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_done_busy got %b%b want 00", done, busy); end
    @(negedge clk);
    reset = 1'b0;
    tick(0, 0, '0);
    n_cmp++; if (busy !== 1'b0 || core_start !== '0) begin n_err++; $display("FAIL idle_no_launch got busy=%b start=%b want 0/0", busy, core_start); end
  endtask

  task automatic test_basic();
    logic [N-1:0] ever, exp;
    bit got;
    num_blocks = 3; lat_mode = 0; lat_fixed = 5; ever = '0; got = 0;
    tick(1, 0, '0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_init_busy got %b want 1", busy); end
    for (int e = 1; e <= 40 && !got; e++) begin
      tick(0, 0, auto_done());
      ever |= core_start;
      if (e >= 2 && e <= 4) begin
        exp = N'((1 << (e - 1)) - 1);
        n_cmp++; if (core_start !== exp) begin n_err++; $display("FAIL basic_dispatch_E%0d got %b want %b", e, core_start, exp); end
        n_cmp++; if (core_block_id[e-2] !== W'(e - 2)) begin n_err++; $display("FAIL basic_id_core%0d got %0d want %0d", e - 2, core_block_id[e-2], e - 2); end
      end
      n_cmp++; if (blocks_done_count !== W'(m_cnt)) begin n_err++; $display("FAIL basic_count_E%0d got %0d want %0d", e, blocks_done_count, m_cnt); end
      if (done) got = 1;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL basic_timeout got done=0 want done=1 within 40 cycles"); end
    n_cmp++; if (blocks_done_count !== 32'd3) begin n_err++; $display("FAIL basic_final_count got %0d want 3", blocks_done_count); end
    n_cmp++; if (ever[3] !== 1'b0) begin n_err++; $display("FAIL basic_core3_idle got %b want 0", ever[3]); end
    tick(0, 0, '0);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_return_idle got done=%b want 0", done); end
  endtask

  task automatic test_zero();
    num_blocks = 0;
    tick(1, 0, '0);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL zero_E0 got busy=%b done=%b want 1/0", busy, done); end
    tick(1, 0, '0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_E1 got done=%b busy=%b want 1/0", done, busy); end
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, '0);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || core_start !== '0) begin
        n_err++; $display("FAIL zero_hold got done=%b busy=%b start=%b want 1/0/0", done, busy, core_start);
      end
    end
    tick(0, 0, '0);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_release got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] all1, r_exp, s_exp;
    all1 = '1; r_exp = 4'b0110; s_exp = 4'b1001;
    num_blocks = 4; lat_mode = 0; lat_fixed = 1000;
    tick(1, 0, '0);
    for (int i = 0; i < 5; i++) tick(0, 0, '0);
    n_cmp++; if (core_start !== all1) begin n_err++; $display("FAIL simul_all_running got %b want %b", core_start, all1); end
    tick(0, 0, 4'b0110);
    n_cmp++; if (blocks_done_count !== 32'd2) begin n_err++; $display("FAIL simul_count got %0d want 2", blocks_done_count); end
    n_cmp++; if (core_reset !== r_exp || core_start !== s_exp) begin
      n_err++; $display("FAIL simul_recycle got reset=%b start=%b want %b/%b", core_reset, core_start, r_exp, s_exp);
    end
    tick(0, 0, 4'b1001);
    n_cmp++; if (done !== 1'b1 || blocks_done_count !== 32'd4) begin
      n_err++; $display("FAIL simul_done got done=%b count=%0d want 1/4", done, blocks_done_count);
    end
    tick(0, 0, '0);
  endtask

  task automatic test_abort();
    logic [N-1:0] all1, three;
    all1 = '1; three = 4'b0111;
    num_blocks = 8; lat_mode = 0; lat_fixed = 1000;
    tick(1, 0, '0);
    for (int i = 0; i < 4; i++) tick(0, 0, '0);
    n_cmp++; if (core_start !== three) begin n_err++; $display("FAIL abort_pre got %b want %b", core_start, three); end
    tick(0, 1, '0);
    n_cmp++; if (core_start !== '0 || core_reset !== all1) begin
      n_err++; $display("FAIL abort_cores got start=%b reset=%b want 0000/%b", core_start, core_reset, all1);
    end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_state got busy=%b done=%b want 0/0", busy, done); end
    num_blocks = 2;
    tick(1, 0, '0);
    tick(0, 0, '0);
    tick(0, 0, '0);
    n_cmp++; if (core_start !== 4'b0001 || core_block_id[0] !== 32'd0) begin
      n_err++; $display("FAIL relaunch_first got start=%b id0=%0d want 0001/0", core_start, core_block_id[0]);
    end
    tick(0, 0, '0);
    n_cmp++; if (core_start !== 4'b0011 || core_block_id[1] !== 32'd1) begin
      n_err++; $display("FAIL relaunch_second got start=%b id1=%0d want 0011/1", core_start, core_block_id[1]);
    end
    tick(0, 0, 4'b0011);
    n_cmp++; if (done !== 1'b1 || blocks_done_count !== 32'd2) begin
      n_err++; $display("FAIL relaunch_done got done=%b count=%0d want 1/2", done, blocks_done_count);
    end
    tick(0, 0, '0);
  endtask

  task automatic test_random();
    int nb, cyc, done_rises, missing;
    logic [N-1:0] prev, rise, noise, cd, all_exp;
    logic [W-1:0] final_cnt, bid;
    bit seen [64];
    bit prev_done;
    for (int run = 0; run < 4; run++) begin
      nb = (run == 0) ? 10 : int'($urandom_range(15, 1));
      num_blocks = W'(nb); lat_mode = 1;
      for (int i = 0; i < 64; i++) seen[i] = 0;
      done_rises = 0; final_cnt = '1; prev_done = 0; cyc = 0;
      prev = core_start;
      tick(1, 0, '0);
      while (m_phase != M_IDLE && cyc < 600) begin
        noise = N'($urandom) & ~exp_start();
        cd = auto_done() | noise;
        tick(0, 0, cd);
        cyc++;
        all_exp = exp_start();
        n_cmp++; if (core_start !== all_exp) begin n_err++; $display("FAIL rand%0d_start cyc%0d got %b want %b", run, cyc, core_start, all_exp); end
        n_cmp++; if (core_reset !== ~all_exp) begin n_err++; $display("FAIL rand%0d_reset cyc%0d got %b want %b", run, cyc, core_reset, ~all_exp); end
        n_cmp++; if (core_block_id !== exp_ids()) begin n_err++; $display("FAIL rand%0d_ids cyc%0d got %h want %h", run, cyc, core_block_id, exp_ids()); end
        n_cmp++; if (blocks_done_count !== W'(m_cnt)) begin n_err++; $display("FAIL rand%0d_count cyc%0d got %0d want %0d", run, cyc, blocks_done_count, m_cnt); end
        n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL rand%0d_done cyc%0d got %b want %b", run, cyc, done, m_done); end
        n_cmp++; if (busy !== (m_phase == M_INIT || m_phase == M_RUN)) begin n_err++; $display("FAIL rand%0d_busy cyc%0d got %b", run, cyc, busy); end
        rise = core_start & ~prev;
        prev = core_start;
        for (int i = 0; i < N; i++) begin
          if (rise[i]) begin
            bid = core_block_id[i];
            n_cmp++;
            if (bid >= W'(nb) || seen[bid[5:0]]) begin
              n_err++; $display("FAIL rand%0d_dup_id core%0d got id %0d want unseen id below %0d", run, i, bid, nb);
            end else seen[bid[5:0]] = 1;
          end
        end
        if (done && !prev_done) begin done_rises++; final_cnt = blocks_done_count; end
        prev_done = done;
      end
      n_cmp++; if (cyc >= 600) begin n_err++; $display("FAIL rand%0d_timeout got %0d cycles want kernel to finish", run, cyc); end
      missing = 0;
      for (int i = 0; i < nb; i++) if (!seen[i]) missing++;
      n_cmp++; if (missing != 0) begin n_err++; $display("FAIL rand%0d_coverage got %0d ids missing want 0", run, missing); end
      n_cmp++; if (done_rises != 1) begin n_err++; $display("FAIL rand%0d_done_once got %0d rises want 1", run, done_rises); end
      n_cmp++; if (final_cnt !== W'(nb)) begin n_err++; $display("FAIL rand%0d_final_count got %0d want %0d", run, final_cnt, nb); end
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] all1, three;
    all1 = '1; three = 4'b0111;
    num_blocks = 6; lat_mode = 0; lat_fixed = 1000;
    tick(1, 0, '0);
    for (int i = 0; i < 4; i++) tick(0, 0, '0);
    n_cmp++; if (core_start !== three) begin n_err++; $display("FAIL areset_pre got %b want %b", core_start, three); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (core_start !== '0 || core_reset !== all1) begin
      n_err++; $display("FAIL areset_cores got start=%b reset=%b want 0000/%b", core_start, core_reset, all1);
    end
    n_cmp++; if (core_block_id !== '0 || blocks_done_count !== '0) begin
      n_err++; $display("FAIL areset_data got ids=%h count=%0d want 0/0", core_block_id, blocks_done_count);
    end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL areset_flags got busy=%b done=%b want 0/0", busy, done); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, '0);
      n_cmp++; if (core_start !== '0 || busy !== 1'b0) begin
        n_err++; $display("FAIL areset_no_relaunch got start=%b busy=%b want 0000/0", core_start, busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_blocks = '0; core_done = '0;
    lat_mode = 0; lat_fixed = 5;
    model_reset();
    test_reset();
    test_basic();
    test_zero();
    test_simultaneous();
    test_abort();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
